icache_tag_array: RTL and testbench

//   N-way set-associative I-cache tag store: per-set tag+valid per way, registered tag compare
//   (hit / hit-way), victim selection and a bulk valid-clear sweep for reset and fence.i.

---
 rtl/icache_tag_array.sv | 186 ++++++++++++++++++
 tb/tb_icache_tag_array.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_tag_array.sv
// icache_tag_array: N-way set-associative I-cache tag store with registered tag compare,
//   victim selection and a one-set-per-cycle valid-clear sweep after reset and fence.i.
// Latency: lookup results appear one cycle after an accepted rd_en_i and hold until the next one.
// Backpressure: none; while busy_o is high (sweep) rd/wr requests are dropped, not queued.
// Ports: clk/rst (sync, active high); rd_* lookup request and result; victim_way_o refill way;
//   wr_* tag/valid write; inv_all_i starts a sweep; busy_o flags the sweep.
// Option: define ICACHE_TAG_PLRU_EN for per-set tree pseudo-LRU replacement; otherwise a
//   single global round-robin counter picks the victim when a set is full.
module icache_tag_array #(
  parameter int WAYS  = 4,
  parameter int SETS  = 64,
  parameter int TAG_W = 55,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic             rd_valid_o,
  output logic             rd_hit_o,
  output logic [WAYS-1:0]  rd_hit_way_o,
  output logic [WAYS-1:0]  victim_way_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [WAYS-1:0]  wr_way_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic             wr_valid_i,
  input  logic             inv_all_i,
  output logic             busy_o
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] sweep_idx_q;
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];

  logic             rd_go;
  logic             wr_go;
  logic [WAYS-1:0]  hit_way_c;
  logic [WAYS-1:0]  invalid_c;
  logic [WAYS-1:0]  victim_c;
  logic [WAY_W-1:0] hit_idx_c;
  logic [WAY_W-1:0] wr_way_idx_c;
  logic [WAY_W-1:0] repl_idx_c;

  assign busy_o = (state_q == SWEEP);
  assign rd_go  = rd_en_i && (state_q == IDLE);
  assign wr_go  = wr_en_i && (state_q == IDLE);

  // Lowest set bit wins; used for the hit way that drives replacement
  // update (multiple hits are illegal but must not break the update).
  function automatic logic [WAY_W-1:0] onehot_to_idx(input logic [WAYS-1:0] oh);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (oh[w]) idx = WAY_W'(w);
    end
    return idx;
  endfunction

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      hit_way_c[w] = valid_q[rd_idx_i][w] && (tag_q[rd_idx_i][w] == rd_tag_i);
    end
  end

  assign hit_idx_c    = onehot_to_idx(hit_way_c);
  assign wr_way_idx_c = onehot_to_idx(wr_way_i);
  assign invalid_c    = ~valid_q[rd_idx_i];

  always_comb begin
    victim_c = '0;
    if (|invalid_c) begin
      // Isolate the lowest invalid way.
      victim_c = invalid_c & (~invalid_c + WAYS'(1));
    end else begin
      victim_c = WAYS'(1) << repl_idx_c;
    end
  end

`ifdef ICACHE_TAG_PLRU_EN
  // Heap-ordered tree: node n (1-based) lives in bit n-1, children 2n / 2n+1.
  // A bit value of 1 points at the upper half, i.e. the victim side.
  logic [WAYS-2:0] plru_q [SETS];
  logic [WAYS-2:0] plru_rd_c;
  logic [WAYS-2:0] plru_wr_base_c;

  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    int node;
    node = 1;
    for (int l = 0; l < WAY_W; l++) node = 2 * node + int'(bits[node-1]);
    return WAY_W'(node - WAYS);
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    int   node;
    logic dir;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      dir           = way[WAY_W-1-l];
      bits[node-1]  = ~dir;
      node          = 2 * node + int'(dir);
    end
    return bits;
  endfunction

  assign repl_idx_c = plru_victim(plru_q[rd_idx_i]);
  assign plru_rd_c  = (|hit_way_c) ? plru_touch(plru_q[rd_idx_i], hit_idx_c) : plru_q[rd_idx_i];
  // Same-set read and write: the write update is applied on top of the read update.
  assign plru_wr_base_c = (rd_go && (wr_idx_i == rd_idx_i)) ? plru_rd_c : plru_q[wr_idx_i];
`else
  logic [WAY_W-1:0] rr_q;
  assign repl_idx_c = rr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SWEEP;
      sweep_idx_q  <= '0;
      rd_valid_o   <= 1'b0;
      rd_hit_o     <= 1'b0;
      rd_hit_way_o <= '0;
      victim_way_o <= '0;
`ifndef ICACHE_TAG_PLRU_EN
      rr_q         <= '0;
`endif
    end else begin
      rd_valid_o <= rd_go;
      if (rd_go) begin
        rd_hit_o     <= |hit_way_c;
        rd_hit_way_o <= hit_way_c;
        victim_way_o <= victim_c;
      end
      if (state_q == SWEEP) begin
`ifndef ICACHE_TAG_PLRU_EN
        rr_q <= '0;
`endif
        if (inv_all_i) begin
          sweep_idx_q <= '0;
        end else begin
          sweep_idx_q <= sweep_idx_q + IDX_W'(1);
          if (sweep_idx_q == IDX_W'(SETS - 1)) state_q <= IDLE;
        end
      end else begin
`ifndef ICACHE_TAG_PLRU_EN
        if (wr_go && wr_valid_i) rr_q <= rr_q + WAY_W'(1);
`endif
        if (inv_all_i) begin
          state_q     <= SWEEP;
          sweep_idx_q <= '0;
        end
      end
    end
  end

  // Storage arrays: no reset of their own, the sweep clears valid/replacement state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == SWEEP) begin
        valid_q[sweep_idx_q] <= '0;
`ifdef ICACHE_TAG_PLRU_EN
        plru_q[sweep_idx_q]  <= '0;
`endif
      end else begin
`ifdef ICACHE_TAG_PLRU_EN
        if (rd_go) plru_q[rd_idx_i] <= plru_rd_c;
        if (wr_go) plru_q[wr_idx_i] <= plru_touch(plru_wr_base_c, wr_way_idx_c);
`endif
        if (wr_go) begin
          for (int w = 0; w < WAYS; w++) begin
            if (wr_way_i[w]) begin
              tag_q[wr_idx_i][w]   <= wr_tag_i;
              valid_q[wr_idx_i][w] <= wr_valid_i;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_tag_array.sv
module tb_icache_tag_array;
  localparam int WAYS  = 4;
  localparam int SETS  = 64;
  localparam int TAG_W = 55;

  logic             clk = 1'b0;
  logic             rst;
  logic             rd_en_i;
  logic [5:0]       rd_idx_i;
  logic [TAG_W-1:0] rd_tag_i;
  logic             rd_valid_o;
  logic             rd_hit_o;
  logic [3:0]       rd_hit_way_o;
  logic [3:0]       victim_way_o;
  logic             wr_en_i;
  logic [5:0]       wr_idx_i;
  logic [3:0]       wr_way_i;
  logic [TAG_W-1:0] wr_tag_i;
  logic             wr_valid_i;
  logic             inv_all_i;
  logic             busy_o;

  always #5 clk = ~clk;

  icache_tag_array #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i), .rd_tag_i(rd_tag_i),
    .rd_valid_o(rd_valid_o), .rd_hit_o(rd_hit_o), .rd_hit_way_o(rd_hit_way_o),
    .victim_way_o(victim_way_o),
    .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i), .wr_way_i(wr_way_i), .wr_tag_i(wr_tag_i),
    .wr_valid_i(wr_valid_i), .inv_all_i(inv_all_i), .busy_o(busy_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: plain per-line tables plus a count of sweep cycles left.
  logic             m_valid [SETS][WAYS];
  logic [TAG_W-1:0] m_tag   [SETS][WAYS];
  logic             m_recent_hi [SETS][WAYS]; // per tree node: 1 = lower half touched last
  int               m_rr;
  int               sweep_left;
  logic             e_vld, e_hit;
  logic [3:0]       e_hw, e_vic;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w]     = 1'b0;
        m_recent_hi[s][w] = 1'b0;
      end
    m_rr = 0;
  endtask

  // Mark way w as most recently used: walk from its leaf up to the root,
  // making each ancestor point at the sibling subtree.
  task automatic touch(input int s, input int w);
    int n;
    n = w + WAYS;
    while (n > 1) begin
      m_recent_hi[s][n/2] = (n % 2 == 0);
      n = n / 2;
    end
  endtask

  function automatic logic [3:0] model_victim(input int s);
    int n;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return 4'(1 << w);
`ifdef ICACHE_TAG_PLRU_EN
    n = 1;
    while (n < WAYS) n = 2 * n + int'(m_recent_hi[s][n]);
    return 4'(1 << (n - WAYS));
`else
    n = m_rr;
    return 4'(1 << n);
`endif
  endfunction

  task automatic check_outputs();
    chk("busy",     64'(busy_o),       64'(sweep_left > 0));
    chk("rd_valid", 64'(rd_valid_o),   64'(e_vld));
    chk("hit",      64'(rd_hit_o),     64'(e_hit));
    chk("hit_way",  64'(rd_hit_way_o), 64'(e_hw));
    chk("victim",   64'(victim_way_o), 64'(e_vic));
  endtask

  task automatic cyc(input logic rde, input logic [5:0] ri, input logic [TAG_W-1:0] rt,
                     input logic wre, input logic [5:0] wi, input logic [3:0] ww,
                     input logic [TAG_W-1:0] wt, input logic wv, input logic inv);
    logic [3:0] hw;
    int         hidx;
    rd_en_i = rde; rd_idx_i = ri; rd_tag_i = rt;
    wr_en_i = wre; wr_idx_i = wi; wr_way_i = ww; wr_tag_i = wt; wr_valid_i = wv;
    inv_all_i = inv;
    hw = '0;
    for (int w = 0; w < WAYS; w++) hw[w] = m_valid[ri][w] && (m_tag[ri][w] == rt);
    e_vld = (sweep_left == 0) && rde;
    if (e_vld) begin
      e_hit = |hw;
      e_hw  = hw;
      e_vic = model_victim(int'(ri));
    end
    @(posedge clk);
    #1;
    if (sweep_left == 0) begin
      if (rde && |hw) begin
        hidx = 0;
        for (int w = WAYS - 1; w >= 0; w--) if (hw[w]) hidx = w;
        touch(int'(ri), hidx);
      end
      if (wre) begin
        for (int w = 0; w < WAYS; w++)
          if (ww[w]) begin
            m_tag[wi][w]   = wt;
            m_valid[wi][w] = wv;
            touch(int'(wi), w);
          end
        if (wv) m_rr = (m_rr + 1) % WAYS;
      end
      if (inv) begin
        clear_model();
        sweep_left = SETS;
      end
    end else begin
      sweep_left = inv ? SETS : sweep_left - 1;
    end
    rd_en_i = 1'b0; wr_en_i = 1'b0; inv_all_i = 1'b0;
    check_outputs();
  endtask

  task automatic idle();
    cyc(0, 6'd0, '0, 0, 6'd0, 4'd0, '0, 0, 0);
  endtask

  task automatic rd(input logic [5:0] i, input logic [TAG_W-1:0] t);
    cyc(1, i, t, 0, 6'd0, 4'd0, '0, 0, 0);
  endtask

  task automatic wr(input logic [5:0] i, input logic [3:0] w, input logic [TAG_W-1:0] t,
                    input logic v);
    cyc(0, 6'd0, '0, 1, i, w, t, v, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rd_en_i = 0; wr_en_i = 0; inv_all_i = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    sweep_left = SETS;
    e_vld = 0; e_hit = 0; e_hw = '0; e_vic = '0;
    check_outputs();
  endtask

  // Counts cycles with busy_o high, bounded so a stuck sweep still ends the run.
  task automatic count_busy(input string name, input logic issue_rd);
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      n++;
      if (issue_rd) rd(6'd7, 55'h700); else idle();
    end
    chk(name, 64'(n), 64'(SETS));
  endtask

  initial begin
    rst = 1'b1; rd_en_i = 0; rd_idx_i = '0; rd_tag_i = '0; wr_en_i = 0; wr_idx_i = '0;
    wr_way_i = '0; wr_tag_i = '0; wr_valid_i = 0; inv_all_i = 0;
    for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) m_tag[s][w] = '0;

    // Reset, sweep length, first lookup misses.
    do_reset();
    chk("reset_busy", 64'(busy_o), 64'd1);
    count_busy("reset_busy_cycles", 1'b0);
    rd(6'd0, 55'h0);
    chk("first_lookup_valid", 64'(rd_valid_o), 64'd1);
    chk("first_lookup_hit",   64'(rd_hit_o),   64'd0);
    idle();
    chk("rd_valid_pulse", 64'(rd_valid_o), 64'd0);

    // Single write then hit / near-miss.
    wr(6'd5, 4'b0010, 55'h1234, 1'b1);
    rd(6'd5, 55'h1234);
    chk("hit_after_write",     64'(rd_hit_o),     64'd1);
    chk("hit_way_after_write", 64'(rd_hit_way_o), 64'b0010);
    rd(6'd5, 55'h1235);
    chk("near_tag_miss", 64'(rd_hit_o), 64'd0);

    // Read-before-write in the same cycle.
    cyc(1, 6'd5, 55'h1234, 1, 6'd5, 4'b0010, 55'h1234, 1'b0, 0);
    chk("rbw_hit", 64'(rd_hit_o), 64'd1);
    rd(6'd5, 55'h1234);
    chk("after_invalidate_write_miss", 64'(rd_hit_o), 64'd0);

    // Fresh state, fill a set in way order, victim falls back to policy.
    do_reset();
    count_busy("reset2_busy_cycles", 1'b0);
    for (int w = 0; w < WAYS; w++) wr(6'd7, 4'(1 << w), 55'(32'h700 + w), 1'b1);
    rd(6'd7, 55'h1);
    chk("full_set_victim", 64'(victim_way_o), 64'b0001);
`ifdef ICACHE_TAG_PLRU_EN
    rd(6'd7, 55'h700);
    chk("plru_hit_way0", 64'(rd_hit_way_o), 64'b0001);
    rd(6'd7, 55'h1);
    chk("plru_victim_after_hit", 64'(victim_way_o), 64'b0100);
`endif
    rd(6'd7, 55'h703);
    chk("hit_way3", 64'(rd_hit_way_o), 64'b1000);

    // fence.i sweep: lookups during it are dropped, earlier hits miss afterwards.
    cyc(0, 6'd0, '0, 0, 6'd0, 4'd0, '0, 0, 1);
    chk("inv_busy", 64'(busy_o), 64'd1);
    count_busy("inv_busy_cycles", 1'b1);
    for (int w = 0; w < WAYS; w++) begin
      rd(6'd7, 55'(32'h700 + w));
      chk("post_inv_miss", 64'(rd_hit_o), 64'd0);
    end

    // Reset in the middle of a sweep restarts it.
    cyc(0, 6'd0, '0, 0, 6'd0, 4'd0, '0, 0, 1);
    for (int i = 0; i < 30; i++) idle();
    do_reset();
    count_busy("midsweep_reset_busy_cycles", 1'b0);

    // Randomized traffic on a few sets with a small tag pool to force hits.
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom % 2), 6'($urandom % 4), 55'($urandom % 4),
          1'($urandom % 3 == 0), 6'($urandom % 4), 4'(1 << ($urandom % 4)),
          55'($urandom % 4), 1'($urandom % 4 != 0), 1'($urandom % 200 == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
